// File: rtl/image_expander_if.sv
// Bus between the compressed-image expander, its SRAM and the pixel consumer.
// The expander drives the SRAM address and the pixel stream; the environment drives start and read data.
interface image_expander_if;
   logic       start;
   logic       sram_rd;
   logic [9:0] sram_addr;
   logic [7:0] sram_rdata;
   logic       pix_valid;
   logic [7:0] pix_color;
   logic [7:0] pix_haddr;
   logic [7:0] pix_vaddr;
   logic       busy;
   logic       done;

   modport master (
      input  start, sram_rdata,
      output sram_rd, sram_addr, pix_valid, pix_color, pix_haddr, pix_vaddr, busy, done
   );

   modport slave (
      output start, sram_rdata,
      input  sram_rd, sram_addr, pix_valid, pix_color, pix_haddr, pix_vaddr, busy, done
   );
endinterface

// File: rtl/image_expander.sv
// Streams an IMG_DIM x IMG_DIM frame by replicating each stored pixel of a
// CMP_DIM x CMP_DIM SRAM image over a SCALE x SCALE block, in raster order.
module image_expander #(
   parameter int IMG_DIM = 224,
   parameter int SCALE   = 8,
   parameter int CMP_DIM = 28,
   parameter int ROW_GAP = 400
) (
   input logic            clk,
   input logic            rst,
   image_expander_if.master bus
);

   localparam int       SHIFT    = $clog2(SCALE);
   localparam int       GAP_W    = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
   localparam int       GAP_LAST = (ROW_GAP > 0) ? ROW_GAP - 1 : 0;
   localparam bit       HAS_GAP  = (ROW_GAP > 0);
   localparam logic [7:0] LAST   = 8'(IMG_DIM - 1);

   typedef enum logic [1:0] {IDLE, ROW, GAP, FIN} state_t;

   state_t             state, state_nx;
   logic [7:0]         col_p0, row_p0;
   logic [9:0]         base_p0;
   logic [GAP_W-1:0]   gap_p0;
   logic               rd_p0, frame_go, row_next, col_inc, gap_inc;

   logic               vld_p1, done_p1;
   logic [7:0]         h_p1, v_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      rd_p0    = 1'b0;
      frame_go = 1'b0;
      row_next = 1'b0;
      col_inc  = 1'b0;
      gap_inc  = 1'b0;
      case (state)
         // done_p1 marks the done cycle, where a new start is still refused
         IDLE: begin
            if (bus.start && !done_p1) begin
               frame_go = 1'b1;
               state_nx = ROW;
            end
         end
         ROW: begin
            rd_p0 = 1'b1;
            if (col_p0 == LAST) begin
               if (row_p0 == LAST) state_nx = FIN;
               else if (!HAS_GAP)  row_next = 1'b1;
               else                state_nx = GAP;
            end else begin
               col_inc = 1'b1;
            end
         end
         GAP: begin
            if (gap_p0 == GAP_W'(GAP_LAST)) begin
               row_next = 1'b1;
               state_nx = ROW;
            end else begin
               gap_inc = 1'b1;
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Stage p0: raster counters and the row-base of the compressed address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_p0  <= 8'd0;
         row_p0  <= 8'd0;
         base_p0 <= 10'd0;
         gap_p0  <= '0;
      end else if (frame_go) begin
         col_p0  <= 8'd0;
         row_p0  <= 8'd0;
         base_p0 <= 10'd0;
         gap_p0  <= '0;
      end else if (row_next) begin
         col_p0 <= 8'd0;
         row_p0 <= row_p0 + 8'd1;
         gap_p0 <= '0;
         if (((row_p0 + 8'd1) & 8'(SCALE - 1)) == 8'd0)
            base_p0 <= base_p0 + 10'(CMP_DIM);
      end else begin
         if (col_inc) col_p0 <= col_p0 + 8'd1;
         if (gap_inc) gap_p0 <= gap_p0 + 1'b1;
      end
   end

   assign bus.sram_rd   = rd_p0;
   assign bus.sram_addr = base_p0 + 10'(col_p0 >> SHIFT);

   // Stage p1: pixel coordinates line up with the SRAM read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         h_p1    <= 8'hFF;
         v_p1    <= 8'hFF;
         done_p1 <= 1'b0;
      end else begin
         vld_p1  <= rd_p0;
         h_p1    <= rd_p0 ? col_p0 : 8'hFF;
         v_p1    <= rd_p0 ? row_p0 : 8'hFF;
         done_p1 <= (state == FIN);
      end
   end

   assign bus.pix_valid = vld_p1;
   assign bus.pix_color = vld_p1 ? bus.sram_rdata : 8'd0;
   assign bus.pix_haddr = h_p1;
   assign bus.pix_vaddr = v_p1;
   assign bus.busy      = (state == ROW) || (state == GAP) || vld_p1;
   assign bus.done      = done_p1;

endmodule
